// File: rtl/gon_y_multicast_bus.sv
// GON Y-bus: FIFO-buffered column fan-out with atomic multicast, broadcast tag,
// unmatched-tag drop, saturating delivery/drop counters and scan-loaded row IDs.
module gon_y_multicast_bus #(
  parameter int MASTER_NUMS = 14,
  parameter int ID_LEN      = 5,
  parameter int ROW_LEN     = 4,
  parameter int VALUE_LEN   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_LEN     = 16,
  parameter int MA_X        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROW_LEN-1:0]     in_row_tag,
  input  logic [ID_LEN-1:0]      in_col_tag,
  input  logic [VALUE_LEN-1:0]   in_value,
  output logic [MASTER_NUMS-1:0] pe_valid,
  input  logic [MASTER_NUMS-1:0] pe_ready,
  output logic [ID_LEN-1:0]      pe_col_tag,
  output logic [VALUE_LEN-1:0]   pe_value,
  input  logic                   set_id,
  input  logic [ROW_LEN-1:0]     id_scan_in,
  output logic [ROW_LEN-1:0]     id_scan_out,
  input  logic                   bcast_en,
  output logic                   busy,
  output logic [CNT_LEN-1:0]     deliver_cnt,
  output logic [CNT_LEN-1:0]     drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ROW_LEN + ID_LEN + VALUE_LEN;

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH || MA_X < 0) begin : g_param_check
    $error("gon_y_multicast_bus: bad FIFO_DEPTH or MA_X");
  end

  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [ROW_LEN-1:0] id_reg [MASTER_NUMS];

  logic                   empty, full, push, pop, deliver, drop, all_rdy;
  logic [EW-1:0]          head;
  logic [ROW_LEN-1:0]     head_row;
  logic [ID_LEN-1:0]      head_col;
  logic [VALUE_LEN-1:0]   head_value;
  logic [MASTER_NUMS-1:0] mask;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = fifo_mem[rd_ptr[AW-1:0]];
  assign {head_row, head_col, head_value} = head;

  assign in_ready = !full && !set_id;
  assign push     = in_valid && in_ready;

  // Broadcast only when enabled and the head row tag is all ones.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MASTER_NUMS; i++) begin
      mask[i] = !empty && ((id_reg[i] == head_row) ||
                           (bcast_en && head_row == {ROW_LEN{1'b1}}));
    end
  end

  assign all_rdy  = &(pe_ready | ~mask);
  assign deliver  = !set_id && (mask != '0) && all_rdy;
  assign drop     = !set_id && !empty && (mask == '0);
  assign pop      = deliver || drop;
  assign pe_valid = deliver ? mask : '0;

  assign pe_col_tag  = empty ? '0 : head_col;
  assign pe_value    = empty ? '0 : head_value;
  assign busy        = !empty;
  assign id_scan_out = id_reg[MASTER_NUMS-1];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_row_tag, in_col_tag, in_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      deliver_cnt <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < MASTER_NUMS; i++) id_reg[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (deliver && deliver_cnt != '1) deliver_cnt <= deliver_cnt + 1'b1;
      if (drop && drop_cnt != '1)       drop_cnt    <= drop_cnt + 1'b1;
      if (set_id) begin
        id_reg[0] <= id_scan_in;
        for (int i = 1; i < MASTER_NUMS; i++) id_reg[i] <= id_reg[i-1];
      end
    end
  end

endmodule

// File: tb/tb_gon_y_multicast_bus.sv
// Directed self-checking bench for gon_y_multicast_bus.
module tb_gon_y_multicast_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_row_tag;
  logic [4:0]  in_col_tag;
  logic [31:0] in_value;
  logic [13:0] pe_valid;
  logic [13:0] pe_ready;
  logic [4:0]  pe_col_tag;
  logic [31:0] pe_value;
  logic        set_id;
  logic [3:0]  id_scan_in;
  logic [3:0]  id_scan_out;
  logic        bcast_en;
  logic        busy;
  logic [15:0] deliver_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  gon_y_multicast_bus dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row_tag(in_row_tag), .in_col_tag(in_col_tag), .in_value(in_value),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_col_tag(pe_col_tag),
    .pe_value(pe_value), .set_id(set_id), .id_scan_in(id_scan_in),
    .id_scan_out(id_scan_out), .bcast_en(bcast_en), .busy(busy),
    .deliver_cnt(deliver_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ids[i] ends up in master i: the highest master's ID is shifted first.
  task automatic load_ids(input logic [3:0] ids [14]);
    set_id = 1'b1;
    for (int i = 13; i >= 0; i--) begin
      id_scan_in = ids[i];
      tick();
    end
    set_id = 1'b0;
    id_scan_in = '0;
  endtask

  task automatic push_pkt(input logic [3:0] row, input logic [4:0] col, input logic [31:0] val);
    in_valid = 1'b1; in_row_tag = row; in_col_tag = col; in_value = val;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_row_tag = 0; in_col_tag = 0; in_value = 0;
    pe_ready = '0; set_id = 0; id_scan_in = 0; bcast_en = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || pe_valid !== 14'h0 || busy !== 1'b0 || pe_value !== 32'h0 ||
        pe_col_tag !== 5'h0 || id_scan_out !== 4'h0 || deliver_cnt !== 16'h0 || drop_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b pe_valid=%h busy=%b val=%h col=%h scan=%h dcnt=%0d xcnt=%0d expected 1 0 0 0 0 0 0 0",
               in_ready, pe_valid, busy, pe_value, pe_col_tag, id_scan_out, deliver_cnt, drop_cnt);
    end
  endtask

  task automatic test_all_zero_ids();
    pe_ready = '1;
    push_pkt(4'h0, 5'h1, 32'h11);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (pe_valid !== 14'h3FFF || pe_value !== 32'h11) begin
      errors++;
      $display("FAIL zero_id_mcast: pe_valid=%h value=%h expected 3fff 00000011", pe_valid, pe_value);
    end
    tick();
    checks++;
    if (deliver_cnt !== 16'd1 || busy !== 1'b0 || pe_valid !== 14'h0) begin
      errors++;
      $display("FAIL zero_id_count: dcnt=%0d busy=%b pe_valid=%h expected 1 0 0", deliver_cnt, busy, pe_valid);
    end
  endtask

  task automatic test_scan_unicast();
    logic [3:0] ids [14];
    for (int i = 0; i < 14; i++) ids[i] = 4'(i);
    set_id = 1'b1; id_scan_in = 4'd13;
    #1;
    checks++;
    if (in_ready !== 1'b0 || pe_valid !== 14'h0) begin
      errors++;
      $display("FAIL scan_blocks: in_ready=%b pe_valid=%h expected 0 0", in_ready, pe_valid);
    end
    load_ids(ids);
    checks++;
    if (id_scan_out !== 4'd13) begin
      errors++;
      $display("FAIL scan_out: got %h expected d", id_scan_out);
    end
    push_pkt(4'd5, 5'd3, 32'hDEADBEEF);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (pe_valid !== 14'h0020 || pe_col_tag !== 5'd3 || pe_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL unicast: pe_valid=%h col=%h val=%h expected 0020 03 deadbeef", pe_valid, pe_col_tag, pe_value);
    end
    tick();
    checks++;
    if (pe_valid !== 14'h0 || deliver_cnt !== 16'd2) begin
      errors++;
      $display("FAIL unicast_once: pe_valid=%h dcnt=%0d expected 0 2", pe_valid, deliver_cnt);
    end
  endtask

  task automatic test_atomic_hold();
    logic [3:0] ids [14];
    for (int i = 0; i < 14; i++) ids[i] = 4'd2;
    ids[1] = 4'd7; ids[4] = 4'd7;
    load_ids(ids);
    pe_ready = 14'h3FEF;
    push_pkt(4'd7, 5'd0, 32'h77);
    tick();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pe_valid !== 14'h0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL atomic_hold[%0d]: pe_valid=%h busy=%b expected 0 1", c, pe_valid, busy);
      end
      tick();
    end
    pe_ready = '1;
    #1;
    checks++;
    if (pe_valid !== 14'h0012 || pe_value !== 32'h77) begin
      errors++;
      $display("FAIL atomic_release: pe_valid=%h val=%h expected 0012 77", pe_valid, pe_value);
    end
    tick();
    checks++;
    if (pe_valid !== 14'h0 || deliver_cnt !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL atomic_done: pe_valid=%h dcnt=%0d busy=%b expected 0 3 0", pe_valid, deliver_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids [14];
    logic pushed;
    for (int i = 0; i < 14; i++) ids[i] = 4'(i);
    load_ids(ids);
    pe_ready = '0;
    for (int k = 0; k < 4; k++) begin
      push_pkt(4'd0, 5'd0, 32'h40 + 32'(k));
      tick();
    end
    push_pkt(4'd0, 5'd0, 32'h44);
    #1;
    checks++;
    if (in_ready !== 1'b0 || pe_valid !== 14'h0) begin
      errors++;
      $display("FAIL fifo_full: in_ready=%b pe_valid=%h expected 0 0", in_ready, pe_valid);
    end
    pe_ready = 14'h0001;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (pe_valid !== 14'h0001 || pe_value !== 32'h40 + 32'(j)) begin
        errors++;
        $display("FAIL b2b[%0d]: pe_valid=%h val=%h expected 0001 %h", j, pe_valid, pe_value, 32'h40 + 32'(j));
      end
      pushed = in_valid && in_ready;
      tick();
      if (pushed) in_valid = 0;
    end
    #1;
    checks++;
    if (pe_valid !== 14'h0 || busy !== 1'b0 || deliver_cnt !== 16'd8) begin
      errors++;
      $display("FAIL b2b_done: pe_valid=%h busy=%b dcnt=%0d expected 0 0 8", pe_valid, busy, deliver_cnt);
    end
  endtask

  task automatic test_drop();
    logic [3:0] ids [14];
    for (int i = 0; i < 14; i++) ids[i] = 4'(i % 8);
    load_ids(ids);
    pe_ready = '1;
    push_pkt(4'd9, 5'd0, 32'h99);
    tick();
    push_pkt(4'd2, 5'd4, 32'h22);
    #1;
    checks++;
    if (pe_valid !== 14'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_nostrobe: pe_valid=%h busy=%b expected 0 1", pe_valid, busy);
    end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (drop_cnt !== 16'd1 || pe_valid !== 14'h0404 || pe_value !== 32'h22 || pe_col_tag !== 5'd4) begin
      errors++;
      $display("FAIL drop_next: xcnt=%0d pe_valid=%h val=%h col=%h expected 1 0404 22 04",
               drop_cnt, pe_valid, pe_value, pe_col_tag);
    end
    tick();
    checks++;
    if (deliver_cnt !== 16'd9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: dcnt=%0d busy=%b expected 9 0", deliver_cnt, busy);
    end
  endtask

  task automatic test_broadcast();
    bcast_en = 1'b1;
    push_pkt(4'hF, 5'd1, 32'hF0);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (pe_valid !== 14'h3FFF) begin
      errors++;
      $display("FAIL bcast_on: pe_valid=%h expected 3fff", pe_valid);
    end
    tick();
    bcast_en = 1'b0;
    push_pkt(4'hF, 5'd1, 32'hF1);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (pe_valid !== 14'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bcast_off: pe_valid=%h busy=%b expected 0 1", pe_valid, busy);
    end
    tick();
    checks++;
    if (drop_cnt !== 16'd2 || deliver_cnt !== 16'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bcast_counts: xcnt=%0d dcnt=%0d busy=%b expected 2 10 0", drop_cnt, deliver_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    pe_ready = '0;
    push_pkt(4'd0, 5'd2, 32'h55);
    tick();
    push_pkt(4'd1, 5'd2, 32'h56);
    tick();
    in_valid = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || pe_value !== 32'h0 || id_scan_out !== 4'h0 ||
        deliver_cnt !== 16'h0 || drop_cnt !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: busy=%b val=%h scan=%h dcnt=%0d xcnt=%0d in_ready=%b expected 0 0 0 0 0 1",
               busy, pe_value, id_scan_out, deliver_cnt, drop_cnt, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero_ids();
    test_scan_unicast();
    test_atomic_hold();
    test_back_to_back();
    test_drop();
    test_broadcast();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
